core_div_arbiter: RTL

- Shares one core_non_restoring unsigned divider among NUM_REQ requesters (per-hart M-extension units) in the multicore cluster.
- Arbitrates round-robin and handles RISC-V DIV/DIVU/REM/REMU and the W variants.
- Converts signed operands to magnitudes, applies sign fix-up, and bypasses divide-by-zero and signed overflow without starting the divider.
- Returns each result to its requester over a valid/ready handshake.

---
 rtl/core_div_pkg.sv | 20 ++
 rtl/core_div_rr_arbiter.sv | 28 ++
 rtl/core_non_restoring.sv | 64 ++++++
 rtl/core_div_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/core_div_pkg.sv
// Shared types for the divider arbiter: RISC-V divide opcodes, FSM states, step count.
package core_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } div_state_e;

    localparam int DIV_STEPS = 64;

endpackage

// File: rtl/core_div_rr_arbiter.sv
// Combinational round-robin grant: first requester strictly after ptr, wrapping.
module core_div_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_non_restoring.sv
// Radix-2 non-restoring unsigned divider: one quotient bit per cycle, done pulses
// in the XLEN-th cycle after the enable cycle.
module core_non_restoring #(
    parameter int XLEN = 64
) (
    input  logic            i_non_restoring_clk,
    input  logic            i_non_restoring_rstn,
    input  logic            en,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done
);

    localparam int RW = XLEN + 2;
    localparam int CW = $clog2(XLEN) + 1;

    logic signed [RW-1:0] rem_q, rem_src, rem_step, shifted, dvs_ext;
    logic [XLEN-1:0]      quo_q, quo_src, quo_step;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;

    // The enable cycle already performs the first step on the freshly loaded operands.
    always_comb begin
        rem_src  = en ? '0 : rem_q;
        quo_src  = en ? dividend : quo_q;
        dvs_ext  = {2'b00, divisor};
        shifted  = {rem_src[RW-2:0], quo_src[XLEN-1]};
        rem_step = rem_src[RW-1] ? (shifted + dvs_ext) : (shifted - dvs_ext);
        quo_step = {quo_src[XLEN-2:0], ~rem_step[RW-1]};
    end

    always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
        if (!i_non_restoring_rstn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                rem_q  <= rem_step;
                quo_q  <= quo_step;
                cnt_q  <= CW'(1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_step;
                quo_q <= quo_step;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    // A negative partial remainder needs one final add-back of the divisor.
    assign quotient  = quo_q;
    assign remainder = rem_q[RW-1] ? (rem_q[XLEN-1:0] + divisor) : rem_q[XLEN-1:0];

endmodule

// File: rtl/core_div_arbiter.sv
// Shares one non-restoring divider among NUM_REQ requesters for RISC-V
// DIV/DIVU/REM/REMU (+W), handling signs and special cases around the divider.
module core_div_arbiter
    import core_div_pkg::*;
#(
    parameter int XLEN    = DIV_STEPS,
    parameter int NUM_REQ = 4
) (
    input  logic                           i_non_restoring_clk,
    input  logic                           i_non_restoring_rstn,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ-1:0][1:0]        i_req_op,
    input  logic [NUM_REQ-1:0]             i_req_word,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   i_req_rs1,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   i_req_rs2,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    input  logic [NUM_REQ-1:0]             i_rsp_ready,
    output logic [XLEN-1:0]                o_rsp_data,
    output logic                           o_busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    div_state_e        state, state_next;
    logic [PW-1:0]     ptr, id, gidx;
    logic [NUM_REQ-1:0] grant;
    logic              accept, word, neg_q, neg_r;
    div_op_e           op, req_op;
    logic [XLEN-1:0]   dvd, dvs, result;
    logic              req_word, is_signed, req_is_rem, a_neg, b_neg;
    logic              div_by_zero, overflow, special;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, most_neg, special_res;
    logic [XLEN-1:0]   raw_res, fixed_res;
    logic              div_start, div_done;
    logic [XLEN-1:0]   div_quo, div_rem;

    function automatic logic [XLEN-1:0] fix_word(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    core_div_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PW)) u_rr (
        .req   (i_req_valid),
        .ptr   (ptr),
        .en    (state == IDLE),
        .grant (grant)
    );

    core_non_restoring #(.XLEN(XLEN)) u_div (
        .i_non_restoring_clk  (i_non_restoring_clk),
        .i_non_restoring_rstn (i_non_restoring_rstn),
        .en                   (div_start),
        .dividend             (dvd),
        .divisor              (dvs),
        .quotient             (div_quo),
        .remainder            (div_rem),
        .done                 (div_done)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gidx = PW'(i);
        end
    end

    assign accept      = |grant;
    assign o_req_ready = grant;

    // Special cases are judged on the extended operands, before taking magnitudes.
    always_comb begin
        req_op      = div_op_e'(i_req_op[gidx]);
        req_word    = i_req_word[gidx];
        is_signed   = (req_op == DIV) || (req_op == REM);
        req_is_rem  = (req_op == REM) || (req_op == REMU);
        a_ext       = req_word ? {{(XLEN-32){is_signed & i_req_rs1[gidx][31]}}, i_req_rs1[gidx][31:0]}
                               : i_req_rs1[gidx];
        b_ext       = req_word ? {{(XLEN-32){is_signed & i_req_rs2[gidx][31]}}, i_req_rs2[gidx][31:0]}
                               : i_req_rs2[gidx];
        a_neg       = is_signed & a_ext[XLEN-1];
        b_neg       = is_signed & b_ext[XLEN-1];
        a_mag       = a_neg ? -a_ext : a_ext;
        b_mag       = b_neg ? -b_ext : b_ext;
        most_neg    = req_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_by_zero = (b_ext == '0);
        overflow    = is_signed && (a_ext == most_neg) && (b_ext == '1);
        special     = div_by_zero || overflow;
        if (req_is_rem) special_res = div_by_zero ? a_ext : '0;
        else            special_res = div_by_zero ? '1 : a_ext;
    end

    always_comb begin
        raw_res   = ((op == REM) || (op == REMU)) ? div_rem : div_quo;
        fixed_res = (((op == DIV) && neg_q) || ((op == REM) && neg_r)) ? -raw_res : raw_res;
    end

    always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
        if (!i_non_restoring_rstn) state <= IDLE;
        else                       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        div_start   = 1'b0;
        o_busy      = 1'b0;
        o_rsp_valid = '0;
        o_rsp_data  = '0;
        case (state)
            IDLE: begin
                if (accept) state_next = special ? RESP : LAUNCH;
            end
            LAUNCH: begin
                o_busy     = 1'b1;
                div_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                o_busy = 1'b1;
                if (div_done) state_next = RESP;
            end
            RESP: begin
                o_busy          = 1'b1;
                o_rsp_valid[id] = 1'b1;
                o_rsp_data      = result;
                if (i_rsp_ready[id]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
        if (!i_non_restoring_rstn) begin
            ptr    <= PW'(NUM_REQ - 1);
            id     <= '0;
            op     <= DIV;
            word   <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (accept) begin
            ptr    <= gidx;
            id     <= gidx;
            op     <= req_op;
            word   <= req_word;
            dvd    <= a_mag;
            dvs    <= b_mag;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            result <= fix_word(req_word, special_res);
        end else if ((state == WAIT) && div_done) begin
            result <= fix_word(word, fixed_res);
        end
    end

endmodule
